// File: rtl/water_ball_pkg.sv
// Water-ball projectile types and screen geometry shared by
// the controller and its per-slot engines.
package water_ball_pkg;

  localparam int SCREEN_W  = 96;
  localparam int SCREEN_H  = 64;
  localparam int SPRITE_SZ = 8;
  localparam int MAX_LEFT  = 88;
  localparam int MAX_TOP   = 56;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLY    = 2'd1,
    SPLASH = 2'd2
  } slot_st_e;

  typedef struct packed {
    slot_st_e    state;
    logic [6:0]  x;
    logic [5:0]  y;
    logic        dir;
    logic [7:0]  splash_cnt;
  } slot_t;

  localparam slot_t SLOT_RST = '{
    state:      IDLE,
    x:          7'd0,
    y:          6'd0,
    dir:        1'b0,
    splash_cnt: 8'd0
  };

endpackage

// File: rtl/water_ball_slot.sv
// One projectile: FSM, move, screen-edge retire, collision, pixel cover.
// WATERBALL_GRAVITY_EN adds a 1 px/tick fall while flying.
module water_ball_slot
  import water_ball_pkg::*;
#(
  parameter int STEP         = 2,
  parameter int SPLASH_TICKS = 4
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       i_load,
  input  logic [6:0] i_x,
  input  logic [5:0] i_y,
  input  logic       i_dir,
  input  logic       i_tick,
  input  logic       i_tgt_valid,
  input  logic [6:0] i_tgt_x,
  input  logic [5:0] i_tgt_y,
  input  logic [6:0] i_px,
  input  logic [5:0] i_py,
  output logic       o_live,
  output logic       o_own,
  output logic       o_hit,
  output logic [6:0] o_x,
  output logic [5:0] o_y
);

  slot_t      r_s;
  slot_t      w_nxt;
  logic [7:0] w_nx;
  logic [7:0] w_ny;
  logic [7:0] w_dx;
  logic [7:0] w_dy;
  logic       w_exit;
  logic       w_coll;

  always_ff @(posedge CLOCK) begin
    if (RESET) r_s <= SLOT_RST;
    else       r_s <= w_nxt;
  end

  // 8-bit arithmetic so a left step below zero is caught, never wrapped
  always_comb begin
    w_nx   = r_s.dir ? {1'b0, r_s.x} + 8'(STEP)
                     : {1'b0, r_s.x} - 8'(STEP);
    w_exit = r_s.dir ? (w_nx > 8'(MAX_LEFT))
                     : ({1'b0, r_s.x} < 8'(STEP));
`ifdef WATERBALL_GRAVITY_EN
    w_ny   = {2'b0, r_s.y} + 8'd1;
    w_exit = w_exit | (w_ny > 8'(MAX_TOP));
`else
    w_ny   = {2'b0, r_s.y};
`endif
    w_dx   = (w_nx >= {1'b0, i_tgt_x}) ? w_nx - {1'b0, i_tgt_x}
                                       : {1'b0, i_tgt_x} - w_nx;
    w_dy   = (w_ny >= {2'b0, i_tgt_y}) ? w_ny - {2'b0, i_tgt_y}
                                       : {2'b0, i_tgt_y} - w_ny;
    w_coll = i_tgt_valid && !w_exit &&
             (w_dx < 8'(SPRITE_SZ)) && (w_dy < 8'(SPRITE_SZ));
  end

  always_comb begin
    w_nxt = r_s;
    o_hit = 1'b0;
    unique case (r_s.state)
      IDLE: begin
        if (i_load) begin
          w_nxt.state      = FLY;
          w_nxt.x          = i_x;
          w_nxt.y          = i_y;
          w_nxt.dir        = i_dir;
          w_nxt.splash_cnt = 8'd0;
        end
      end
      FLY: begin
        if (i_tick) begin
          if (w_exit) begin
            w_nxt.state = IDLE;
          end else begin
            w_nxt.x = w_nx[6:0];
            w_nxt.y = w_ny[5:0];
            if (w_coll) begin
              w_nxt.state      = SPLASH;
              w_nxt.splash_cnt = 8'(SPLASH_TICKS);
              o_hit            = 1'b1;
            end
          end
        end
      end
      SPLASH: begin
        if (i_tick) begin
          w_nxt.splash_cnt = r_s.splash_cnt - 8'd1;
          if (r_s.splash_cnt <= 8'd1) w_nxt.state = IDLE;
        end
      end
      default: w_nxt.state = IDLE;
    endcase
  end

  assign o_live = (r_s.state != IDLE);
  assign o_own  = o_live &&
                  ({1'b0, i_px} >= {1'b0, r_s.x}) &&
                  ({1'b0, i_px} <= {1'b0, r_s.x} + 8'd7) &&
                  ({2'b0, i_py} >= {2'b0, r_s.y}) &&
                  ({2'b0, i_py} <= {2'b0, r_s.y} + 8'd7);
  assign o_x    = r_s.x;
  assign o_y    = r_s.y;

endmodule

// File: rtl/water_ball_ctrl.sv
// Water-ball controller: launch, cooldown, sprite pixel arbiter, hits.
// Optional gravity lives in water_ball_slot under WATERBALL_GRAVITY_EN.
module water_ball_ctrl
  import water_ball_pkg::*;
#(
  parameter int SLOTS        = 4,
  parameter int STEP         = 2,
  parameter int COOLDOWN     = 3,
  parameter int SPLASH_TICKS = 4
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             fire_req,
  input  logic [6:0]       fire_x,
  input  logic [5:0]       fire_y,
  input  logic             fire_dir,
  output logic             fire_ack,
  input  logic             move_tick,
  input  logic             target_valid,
  input  logic [6:0]       target_x,
  input  logic [5:0]       target_y,
  input  logic [6:0]       X,
  input  logic [5:0]       Y,
  output logic [6:0]       ball_leftX,
  output logic [5:0]       ball_topY,
  output logic             ball_hit,
  output logic [SLOTS-1:0] active_mask,
  output logic             hit_pulse,
  output logic [7:0]       hit_count
);

  logic [SLOTS-1:0] w_live;
  logic [SLOTS-1:0] w_own;
  logic [SLOTS-1:0] w_hit;
  logic [SLOTS-1:0] w_load;
  logic [6:0]       w_x [SLOTS];
  logic [5:0]       w_y [SLOTS];
  logic             w_found;
  logic             w_accept;
  logic             w_any;
  logic [6:0]       w_sel_x;
  logic [5:0]       w_sel_y;
  logic [3:0]       w_nhits;
  logic [8:0]       w_sum;

  logic [7:0]       r_cd;
  logic             r_ack;
  logic             r_hitp;
  logic [7:0]       r_cnt;
  logic             r_bhit;
  logic [6:0]       r_bx;
  logic [5:0]       r_by;

  for (genvar g = 0; g < SLOTS; g++) begin : g_slot
    water_ball_slot #(
      .STEP        (STEP),
      .SPLASH_TICKS(SPLASH_TICKS)
    ) u_slot (
      .CLOCK      (CLOCK),
      .RESET      (RESET),
      .i_load     (w_load[g]),
      .i_x        (fire_x),
      .i_y        (fire_y),
      .i_dir      (fire_dir),
      .i_tick     (move_tick),
      .i_tgt_valid(target_valid),
      .i_tgt_x    (target_x),
      .i_tgt_y    (target_y),
      .i_px       (X),
      .i_py       (Y),
      .o_live     (w_live[g]),
      .o_own      (w_own[g]),
      .o_hit      (w_hit[g]),
      .o_x        (w_x[g]),
      .o_y        (w_y[g])
    );
  end

  always_comb begin
    w_load  = '0;
    w_found = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      if (!w_live[i] && !w_found) begin
        w_load[i] = 1'b1;
        w_found   = 1'b1;
      end
    end
    w_accept = fire_req && (r_cd == 8'd0) && w_found;
    if (!w_accept) w_load = '0;
  end

  always_comb begin
    w_any   = 1'b0;
    w_sel_x = 7'd0;
    w_sel_y = 6'd0;
    w_nhits = 4'd0;
    for (int i = 0; i < SLOTS; i++) begin
      if (w_own[i] && !w_any) begin
        w_any   = 1'b1;
        w_sel_x = w_x[i];
        w_sel_y = w_y[i];
      end
      w_nhits = w_nhits + {3'b0, w_hit[i]};
    end
    w_sum = {1'b0, r_cnt} + {5'b0, w_nhits};
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_cd   <= 8'd0;
      r_ack  <= 1'b0;
      r_hitp <= 1'b0;
      r_cnt  <= 8'd0;
      r_bhit <= 1'b0;
      r_bx   <= 7'd0;
      r_by   <= 6'd0;
    end else begin
      if (w_accept)
        r_cd <= 8'(COOLDOWN);
      else if (move_tick && r_cd != 8'd0)
        r_cd <= r_cd - 8'd1;
      r_ack  <= w_accept;
      r_hitp <= |w_hit;
      r_cnt  <= (w_sum > 9'd255) ? 8'd255 : w_sum[7:0];
      r_bhit <= w_any;
      r_bx   <= w_sel_x;
      r_by   <= w_sel_y;
    end
  end

  assign fire_ack    = r_ack;
  assign hit_pulse   = r_hitp;
  assign hit_count   = r_cnt;
  assign ball_hit    = r_bhit;
  assign ball_leftX  = r_bx;
  assign ball_topY   = r_by;
  assign active_mask = w_live;

endmodule

// File: tb/tb_water_ball_ctrl.sv
// Bench for water_ball_ctrl: directed scenarios plus random traffic,
// all outputs checked each cycle against an integer reference model.
module tb_water_ball_ctrl;

  localparam int SLOTS        = 4;
  localparam int STEP         = 2;
  localparam int COOLDOWN     = 3;
  localparam int SPLASH_TICKS = 4;

  logic             CLOCK = 1'b0;
  logic             RESET;
  logic             fire_req;
  logic [6:0]       fire_x;
  logic [5:0]       fire_y;
  logic             fire_dir;
  logic             fire_ack;
  logic             move_tick;
  logic             target_valid;
  logic [6:0]       target_x;
  logic [5:0]       target_y;
  logic [6:0]       X;
  logic [5:0]       Y;
  logic [6:0]       ball_leftX;
  logic [5:0]       ball_topY;
  logic             ball_hit;
  logic [SLOTS-1:0] active_mask;
  logic             hit_pulse;
  logic [7:0]       hit_count;

  int n_cmp = 0;
  int n_err = 0;

  bit m_live [SLOTS];
  int m_x    [SLOTS];
  int m_y    [SLOTS];
  int m_spl  [SLOTS];
  bit m_dir  [SLOTS];
  int m_cd;
  int e_cnt;
  bit e_ack;
  bit e_hp;
  bit e_bh;
  int e_bx;
  int e_by;

  always #5 CLOCK = ~CLOCK;

  water_ball_ctrl #(
    .SLOTS(SLOTS), .STEP(STEP),
    .COOLDOWN(COOLDOWN), .SPLASH_TICKS(SPLASH_TICKS)
  ) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .fire_req(fire_req), .fire_x(fire_x),
    .fire_y(fire_y), .fire_dir(fire_dir),
    .fire_ack(fire_ack), .move_tick(move_tick),
    .target_valid(target_valid),
    .target_x(target_x), .target_y(target_y),
    .X(X), .Y(Y),
    .ball_leftX(ball_leftX), .ball_topY(ball_topY),
    .ball_hit(ball_hit), .active_mask(active_mask),
    .hit_pulse(hit_pulse), .hit_count(hit_count)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Advance the model by one clock using the current inputs,
  // then clock the DUT and compare every output.
  task automatic cyc();
    int own, idle, nh, nx, ny, px, py;
    bit acc;
    logic [SLOTS-1:0] em;
    if (RESET) begin
      for (int i = 0; i < SLOTS; i++) begin
        m_live[i] = 0;
        m_spl[i]  = 0;
      end
      m_cd = 0; e_cnt = 0; e_ack = 0;
      e_hp = 0; e_bh = 0; e_bx = 0; e_by = 0;
    end else begin
      px = int'(X);
      py = int'(Y);
      own = -1;
      for (int i = 0; i < SLOTS; i++)
        if (own < 0 && m_live[i] &&
            px >= m_x[i] && px <= m_x[i] + 7 &&
            py >= m_y[i] && py <= m_y[i] + 7)
          own = i;
      e_bh = (own >= 0);
      e_bx = (own >= 0) ? m_x[own] : 0;
      e_by = (own >= 0) ? m_y[own] : 0;
      idle = -1;
      for (int i = 0; i < SLOTS; i++)
        if (idle < 0 && !m_live[i]) idle = i;
      acc = fire_req && m_cd == 0 && idle >= 0;
      nh = 0;
      if (move_tick) begin
        for (int i = 0; i < SLOTS; i++) begin
          if (!m_live[i]) continue;
          if (m_spl[i] > 0) begin
            m_spl[i]--;
            if (m_spl[i] == 0) m_live[i] = 0;
          end else begin
            nx = m_dir[i] ? m_x[i] + STEP : m_x[i] - STEP;
`ifdef WATERBALL_GRAVITY_EN
            ny = m_y[i] + 1;
`else
            ny = m_y[i];
`endif
            if (nx < 0 || nx > 88 || ny > 56) begin
              m_live[i] = 0;
            end else begin
              m_x[i] = nx;
              m_y[i] = ny;
              if (target_valid &&
                  iabs(nx - int'(target_x)) < 8 &&
                  iabs(ny - int'(target_y)) < 8) begin
                m_spl[i] = SPLASH_TICKS;
                nh++;
              end
            end
          end
        end
      end
      if (acc) m_cd = COOLDOWN;
      else if (move_tick && m_cd > 0) m_cd--;
      if (acc) begin
        m_live[idle] = 1;
        m_spl[idle]  = 0;
        m_x[idle]    = int'(fire_x);
        m_y[idle]    = int'(fire_y);
        m_dir[idle]  = fire_dir;
      end
      e_ack = acc;
      e_hp  = (nh > 0);
      e_cnt = (e_cnt + nh > 255) ? 255 : e_cnt + nh;
    end
    @(posedge CLOCK);
    #1;
    for (int i = 0; i < SLOTS; i++) em[i] = m_live[i];
    chk("fire_ack",    32'(fire_ack),    32'(e_ack));
    chk("active_mask", 32'(active_mask), 32'(em));
    chk("hit_pulse",   32'(hit_pulse),   32'(e_hp));
    chk("hit_count",   32'(hit_count),   32'(e_cnt));
    chk("ball_hit",    32'(ball_hit),    32'(e_bh));
    chk("ball_leftX",  32'(ball_leftX),  32'(e_bx));
    chk("ball_topY",   32'(ball_topY),   32'(e_by));
  endtask

  task automatic do_reset();
    RESET = 1'b1; fire_req = 1'b0; move_tick = 1'b0;
    cyc();
    RESET = 1'b0;
  endtask

  task automatic fire(input int fx, input int fy, input bit d);
    fire_req = 1'b1;
    fire_x   = 7'(fx);
    fire_y   = 6'(fy);
    fire_dir = d;
    cyc();
    fire_req = 1'b0;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      move_tick = 1'b1; cyc();
      move_tick = 1'b0; cyc();
    end
  endtask

  initial begin
    int k;
    RESET = 1'b1; fire_req = 1'b0; fire_x = '0; fire_y = '0;
    fire_dir = 1'b0; move_tick = 1'b0; target_valid = 1'b0;
    target_x = '0; target_y = '0; X = '0; Y = '0;
    m_cd = 0; e_cnt = 0;
    for (int i = 0; i < SLOTS; i++) begin
      m_live[i] = 0; m_x[i] = 0; m_y[i] = 0;
      m_spl[i] = 0; m_dir[i] = 0;
    end

    do_reset();
    do_reset();
    chk("rst_mask", 32'(active_mask), 32'd0);

    // single launch and flight
    fire(10, 20, 1'b1);
    chk("l1_ack",  32'(fire_ack),    32'd1);
    chk("l1_mask", 32'(active_mask), 32'd1);
    tick(5);
    X = 7'd20; Y = 6'd27;
    cyc();
    chk("l1_bhit", 32'(ball_hit),   32'd1);
    chk("l1_x",    32'(ball_leftX), 32'd20);

    // right edge: 86 -> 88 stays, next step exits
    do_reset();
    fire(86, 0, 1'b1);
    tick(1);
    chk("edge_88", 32'(active_mask), 32'd1);
    tick(1);
    chk("exit_r",  32'(active_mask), 32'd0);
    do_reset();
    fire(1, 0, 1'b0);
    tick(1);
    chk("exit_l",  32'(active_mask), 32'd0);
    chk("exit_hp", 32'(hit_pulse),   32'd0);

    // collision and splash retire
    do_reset();
    target_valid = 1'b1; target_x = 7'd30; target_y = 6'd20;
    fire(20, 20, 1'b1);
    move_tick = 1'b1; cyc(); move_tick = 1'b0; cyc();
    chk("coll_miss", 32'(hit_count), 32'd0);
    move_tick = 1'b1; cyc(); move_tick = 1'b0;
    chk("coll_hp",   32'(hit_pulse), 32'd1);
    chk("coll_cnt",  32'(hit_count), 32'd1);
    cyc();
    chk("coll_hp1",  32'(hit_pulse), 32'd0);
    tick(3);
    chk("splash_on", 32'(active_mask), 32'd1);
    tick(1);
    chk("splash_off", 32'(active_mask), 32'd0);
    target_valid = 1'b0;

    // overlapping balls: lowest index wins the pixel
    do_reset();
    fire(34, 10, 1'b1);
    tick(3);
    fire(44, 10, 1'b1);
`ifdef WATERBALL_GRAVITY_EN
    X = 7'd45; Y = 6'd14;
`else
    X = 7'd45; Y = 6'd12;
`endif
    cyc();
    chk("arb_hit", 32'(ball_hit),   32'd1);
    chk("arb_x",   32'(ball_leftX), 32'd40);
    X = 7'd0; Y = 6'd63;
    cyc();
    chk("arb_none", 32'(ball_hit),  32'd0);
    chk("arb_nx",   32'(ball_leftX), 32'd0);

    // held fire_req: cooldown spacing and full-slot stall
    do_reset();
    fire_req = 1'b1; fire_x = 7'd88; fire_y = 6'd30; fire_dir = 1'b0;
    for (int c = 0; c < 180; c++) begin
      move_tick = (c % 3 == 0);
      cyc();
    end
    fire_req = 1'b0; move_tick = 1'b0;

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      fire_req  = ($urandom_range(0, 3) == 0);
      fire_x    = 7'($urandom_range(0, 88));
      fire_y    = 6'($urandom_range(0, 56));
      fire_dir  = 1'($urandom_range(0, 1));
      move_tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 39) == 0) begin
        target_valid = ($urandom_range(0, 3) != 0);
        target_x     = 7'($urandom_range(0, 88));
        target_y     = 6'($urandom_range(0, 56));
      end
      k = $urandom_range(0, SLOTS - 1);
      if (m_live[k] && $urandom_range(0, 1) == 1) begin
        X = 7'(m_x[k] + $urandom_range(0, 7));
        Y = 6'(m_y[k] + $urandom_range(0, 7));
      end else begin
        X = 7'($urandom_range(0, 95));
        Y = 6'($urandom_range(0, 63));
      end
      RESET = ($urandom_range(0, 599) == 0);
      cyc();
    end
    RESET = 1'b0; fire_req = 1'b0; move_tick = 1'b0;

    // reset while balls are in flight
    do_reset();
    target_valid = 1'b0;
    fire(10, 5, 1'b1);
    tick(3);
    fire(40, 30, 1'b0);
    tick(3);
    fire(60, 40, 1'b1);
    chk("mf_live", 32'(active_mask), 32'd7);
    fire_req = 1'b1;
    RESET = 1'b1;
    cyc();
    RESET = 1'b0; fire_req = 1'b0;
    chk("mf_mask", 32'(active_mask), 32'd0);
    chk("mf_ack",  32'(fire_ack),    32'd0);
    chk("mf_cnt",  32'(hit_count),   32'd0);
    chk("mf_bhit", 32'(ball_hit),    32'd0);
    cyc();
    chk("mf_ack2", 32'(fire_ack),    32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
